gpr_sb: RTL and testbench

GPR_SB -- requirements
Module: gpr_sb

---
 rtl/gpr_sb.sv | 107 ++++++++++
 tb/tb_gpr_sb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_sb.sv
// gpr_sb: general-purpose register file with a per-register busy scoreboard.
//
// Three combinational read ports (Rx, Ry, Rz) each return a value and that
// register's busy flag. One writeback port (WB_*) stores data and clears the
// busy flag of its register. ISSUE marks Rz busy unless any addressed
// register is busy, in which case HAZARD is raised and nothing changes.
//
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   Rx, Ry, Rz     [ADDR_W]     read addresses (Rz is also the issue target)
//   ISSUE                       request to mark Rz busy
//   WB_EN, WB_ADDR, WB_DATA     writeback strobe, address, data
//   Rx/Ry/Rz_value [DATA_W]     read data
//   Rx/Ry/Rz_busy               scoreboard status of the addressed register
//   HAZARD                      the issue is rejected this cycle
module gpr_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] Rx,
  input  logic [ADDR_W-1:0] Ry,
  input  logic [ADDR_W-1:0] Rz,
  input  logic              ISSUE,
  input  logic              WB_EN,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic [DATA_W-1:0] Rx_value,
  output logic [DATA_W-1:0] Ry_value,
  output logic [DATA_W-1:0] Rz_value,
  output logic              Rx_busy,
  output logic              Ry_busy,
  output logic              Rz_busy,
  output logic              HAZARD
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic [ADDR_W-1:0] w_ra  [3];
  logic [DATA_W-1:0] w_val [3];
  logic              w_bsy [3];
  logic              w_hazard;
  logic              w_wb_r0;
  logic              w_rz_r0;

  assign w_ra[0] = Rx;
  assign w_ra[1] = Ry;
  assign w_ra[2] = Rz;

  assign w_wb_r0 = (ZERO_R0 != 0) && (WB_ADDR == '0);
  assign w_rz_r0 = (ZERO_R0 != 0) && (Rz == '0);

  // Each port resolves independently: hardwired R0 first, then the
  // same-cycle writeback forward, then stored state.
  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      w_val[p] = '0;
      w_bsy[p] = 1'b0;
      if ((ZERO_R0 != 0) && (w_ra[p] == '0)) begin
        w_val[p] = '0;
        w_bsy[p] = 1'b0;
      end else if ((BYPASS != 0) && WB_EN && (WB_ADDR == w_ra[p])) begin
        w_val[p] = WB_DATA;
        w_bsy[p] = 1'b0;
      end else begin
        w_val[p] = r_regs[w_ra[p]];
        w_bsy[p] = r_busy[w_ra[p]];
      end
    end
  end

  assign Rx_value = w_val[0];
  assign Ry_value = w_val[1];
  assign Rz_value = w_val[2];
  assign Rx_busy  = w_bsy[0];
  assign Ry_busy  = w_bsy[1];
  assign Rz_busy  = w_bsy[2];

  assign w_hazard = ISSUE && (w_bsy[0] || w_bsy[1] || w_bsy[2]);
  assign HAZARD   = w_hazard;

  // The issue set is placed after the writeback clear so that an accepted
  // issue to the address being written back leaves the register busy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (WB_EN && !w_wb_r0) begin
        r_regs[WB_ADDR] <= WB_DATA;
        r_busy[WB_ADDR] <= 1'b0;
      end
      if (ISSUE && !w_hazard && !w_rz_r0) begin
        r_busy[Rz] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpr_sb.sv
module tb_gpr_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rx, ry, rz, wb_addr;
  logic        issue, wb_en;
  logic [15:0] wb_data;

  // Instance 0: defaults. Instance 1: BYPASS=0. Instance 2: ZERO_R0=1.
  logic [15:0] rxv [3];
  logic [15:0] ryv [3];
  logic [15:0] rzv [3];
  logic        rxb [3];
  logic        ryb [3];
  logic        rzb [3];
  logic        hz  [3];

  // Wide instance: DATA_W=32, ADDR_W=5.
  logic [4:0]  d_rx, d_ry, d_rz, d_wb_addr;
  logic        d_issue, d_wb_en;
  logic [31:0] d_wb_data;
  logic [31:0] d_rxv, d_ryv, d_rzv;
  logic        d_rxb, d_ryb, d_rzb, d_hz;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gpr_sb #(
      .DATA_W (16),
      .ADDR_W (4),
      .ZERO_R0((g == 2) ? 1 : 0),
      .BYPASS ((g == 1) ? 0 : 1)
    ) u_dut (
      .CLK(clk), .RST(rst), .Rx(rx), .Ry(ry), .Rz(rz), .ISSUE(issue),
      .WB_EN(wb_en), .WB_ADDR(wb_addr), .WB_DATA(wb_data),
      .Rx_value(rxv[g]), .Ry_value(ryv[g]), .Rz_value(rzv[g]),
      .Rx_busy(rxb[g]), .Ry_busy(ryb[g]), .Rz_busy(rzb[g]), .HAZARD(hz[g])
    );
  end

  gpr_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(0), .BYPASS(1)) u_wide (
    .CLK(clk), .RST(rst), .Rx(d_rx), .Ry(d_ry), .Rz(d_rz), .ISSUE(d_issue),
    .WB_EN(d_wb_en), .WB_ADDR(d_wb_addr), .WB_DATA(d_wb_data),
    .Rx_value(d_rxv), .Ry_value(d_ryv), .Rz_value(d_rzv),
    .Rx_busy(d_rxb), .Ry_busy(d_ryb), .Rz_busy(d_rzb), .HAZARD(d_hz)
  );

  typedef struct {
    logic        issue;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  rx, ry, rz;
    logic [15:0] ex_rx, ex_ry, ex_rz;
    logic [2:0]  ex_busy;  // {x, y, z}
    logic        ex_hz;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic is, input logic we, input logic [3:0] wa,
                              input logic [15:0] wd, input logic [3:0] ax, input logic [3:0] ay,
                              input logic [3:0] az, input logic [15:0] ex, input logic [15:0] ey,
                              input logic [15:0] ez, input logic [2:0] eb, input logic eh);
    vec_t v;
    v.issue = is; v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
    v.rx = ax; v.ry = ay; v.rz = az;
    v.ex_rx = ex; v.ex_ry = ey; v.ex_rz = ez; v.ex_busy = eb; v.ex_hz = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic is, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic [3:0] ax, input logic [3:0] ay,
                       input logic [3:0] az);
    issue = is; wb_en = we; wb_addr = wa; wb_data = wd;
    rx = ax; ry = ay; rz = az;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    d_rx = '0; d_ry = '0; d_rz = '0; d_issue = 1'b0;
    d_wb_en = 1'b0; d_wb_addr = '0; d_wb_data = '0;

    //            is we wa  wd       rx  ry  rz  ex_rx    ex_ry    ex_rz    busy    hz
    tbl[0]  = mk(0, 1, 5,  16'h1234, 5,  0,  5,  16'h1234, 16'h0,  16'h1234, 3'b000, 0);
    tbl[1]  = mk(0, 0, 0,  16'h0,    5,  5,  1,  16'h1234, 16'h1234, 16'h0,  3'b000, 0);
    tbl[2]  = mk(1, 0, 0,  16'h0,    0,  0,  3,  16'h0,    16'h0,  16'h0,    3'b000, 0);
    tbl[3]  = mk(0, 0, 0,  16'h0,    3,  1,  3,  16'h0,    16'h0,  16'h0,    3'b101, 0);
    tbl[4]  = mk(1, 0, 0,  16'h0,    3,  0,  4,  16'h0,    16'h0,  16'h0,    3'b100, 1);
    tbl[5]  = mk(0, 0, 0,  16'h0,    4,  3,  3,  16'h0,    16'h0,  16'h0,    3'b011, 0);
    tbl[6]  = mk(1, 1, 3,  16'h00AA, 3,  3,  3,  16'h00AA, 16'h00AA, 16'h00AA, 3'b000, 0);
    tbl[7]  = mk(0, 0, 0,  16'h0,    3,  7,  7,  16'h00AA, 16'h0,  16'h0,    3'b100, 0);
    tbl[8]  = mk(1, 1, 7,  16'h5555, 0,  0,  7,  16'h0,    16'h0,  16'h5555, 3'b000, 0);
    tbl[9]  = mk(0, 0, 0,  16'h0,    7,  3,  7,  16'h5555, 16'h00AA, 16'h5555, 3'b111, 0);
    tbl[10] = mk(1, 1, 3,  16'h0BBB, 1,  2,  8,  16'h0,    16'h0,  16'h0,    3'b000, 0);
    tbl[11] = mk(0, 0, 0,  16'h0,    8,  3,  7,  16'h0,    16'h0BBB, 16'h5555, 3'b101, 0);
    tbl[12] = mk(0, 1, 9,  16'h0909, 9,  15, 0,  16'h0909, 16'h0,  16'h0,    3'b000, 0);
    tbl[13] = mk(0, 0, 0,  16'h0,    9,  9,  9,  16'h0909, 16'h0909, 16'h0909, 3'b000, 0);
    tbl[14] = mk(0, 1, 0,  16'hFFFF, 0,  0,  0,  16'hFFFF, 16'hFFFF, 16'hFFFF, 3'b000, 0);
    tbl[15] = mk(0, 0, 0,  16'h0,    0,  15, 0,  16'hFFFF, 16'h0,  16'hFFFF, 3'b000, 0);
    tbl[16] = mk(1, 0, 0,  16'h0,    0,  8,  15, 16'hFFFF, 16'h0,  16'h0,    3'b010, 1);
    tbl[17] = mk(0, 0, 0,  16'h0,    15, 8,  15, 16'h0,    16'h0,  16'h0,    3'b010, 0);

    // Reset state: every address reads zero and not busy.
    #2;
    for (int a = 0; a < 16; a++) begin
      rx = 4'(a); ry = 4'(a); rz = 4'(a);
      #1;
      chk($sformatf("rst val a%0d", a), {16'h0, rxv[0]}, 32'h0);
      chk($sformatf("rst busy a%0d", a), {29'h0, rxb[0], ryb[0], rzb[0]}, 32'h0);
    end
    chk("rst hazard", {31'h0, hz[0]}, 32'h0);
    next_cycle();
    rst = 1'b0;

    // Table-driven vectors on the default instance.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].issue, tbl[i].wb_en, tbl[i].wb_addr, tbl[i].wb_data,
            tbl[i].rx, tbl[i].ry, tbl[i].rz);
      @(negedge clk);
      chk($sformatf("v%0d rx_value", i), {16'h0, rxv[0]}, {16'h0, tbl[i].ex_rx});
      chk($sformatf("v%0d ry_value", i), {16'h0, ryv[0]}, {16'h0, tbl[i].ex_ry});
      chk($sformatf("v%0d rz_value", i), {16'h0, rzv[0]}, {16'h0, tbl[i].ex_rz});
      chk($sformatf("v%0d busy", i), {29'h0, rxb[0], ryb[0], rzb[0]}, {29'h0, tbl[i].ex_busy});
      chk($sformatf("v%0d hazard", i), {31'h0, hz[0]}, {31'h0, tbl[i].ex_hz});
      next_cycle();
    end

    // Asynchronous reset mid-operation clears 0xBEEF and pending busy bits.
    drive(0, 1, 5, 16'hBEEF, 5, 8, 7);
    next_cycle();
    drive(0, 0, 0, 0, 5, 8, 7);
    @(negedge clk);
    chk("pre-rst beef", {16'h0, rxv[0]}, 32'h0000BEEF);
    chk("pre-rst busy", {29'h0, rxb[0], ryb[0], rzb[0]}, 32'h3);
    #1 rst = 1'b1;
    #1;
    chk("async rst val", {16'h0, rxv[0]}, 32'h0);
    chk("async rst busy", {29'h0, rxb[0], ryb[0], rzb[0]}, 32'h0);
    drive(1, 1, 5, 16'h4321, 5, 8, 7);
    #1;
    chk("rst bypass A", {16'h0, rxv[0]}, 32'h00004321);
    chk("rst bypass B", {16'h0, rxv[1]}, 32'h0);
    next_cycle();
    drive(0, 0, 0, 0, 5, 8, 7);
    #1;
    chk("rst no write", {16'h0, rxv[0]}, 32'h0);
    chk("rst no issue", {31'h0, rzb[0]}, 32'h0);
    #1 rst = 1'b0;
    next_cycle();

    // Hand sequence across the three 16-bit instances.
    drive(0, 1, 5, 16'h1234, 5, 5, 5);
    @(negedge clk);
    chk("h1 A bypass", {16'h0, rxv[0]}, 32'h00001234);
    chk("h1 B no bypass", {16'h0, rxv[1]}, 32'h0);
    chk("h1 C bypass", {16'h0, rxv[2]}, 32'h00001234);
    next_cycle();
    drive(1, 0, 0, 0, 5, 7, 3);
    @(negedge clk);
    chk("h2 B stored", {16'h0, rxv[1]}, 32'h00001234);
    chk("h2 A fresh hazard", {31'h0, hz[0]}, 32'h0);
    next_cycle();
    drive(0, 1, 3, 16'h00AA, 3, 0, 0);
    @(negedge clk);
    chk("h3 A busy fwd", {31'h0, rxb[0]}, 32'h0);
    chk("h3 A val fwd", {16'h0, rxv[0]}, 32'h000000AA);
    chk("h3 B busy held", {31'h0, rxb[1]}, 32'h1);
    chk("h3 B val old", {16'h0, rxv[1]}, 32'h0);
    next_cycle();
    drive(0, 0, 0, 0, 3, 0, 0);
    @(negedge clk);
    chk("h4 B busy clr", {31'h0, rxb[1]}, 32'h0);
    chk("h4 B val new", {16'h0, rxv[1]}, 32'h000000AA);
    next_cycle();
    drive(1, 1, 0, 16'hFFFF, 0, 0, 0);
    @(negedge clk);
    chk("h5 C r0 val", {16'h0, rxv[2]}, 32'h0);
    chk("h5 C r0 busy", {31'h0, rzb[2]}, 32'h0);
    chk("h5 C hazard", {31'h0, hz[2]}, 32'h0);
    chk("h5 A r0 fwd", {16'h0, rxv[0]}, 32'h0000FFFF);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("h6 C r0 val", {16'h0, rxv[2]}, 32'h0);
    chk("h6 C r0 busy", {31'h0, rzb[2]}, 32'h0);
    chk("h6 C hazard", {31'h0, hz[2]}, 32'h0);
    chk("h6 A hazard", {31'h0, hz[0]}, 32'h1);
    chk("h6 A r0 val", {16'h0, rxv[0]}, 32'h0000FFFF);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);

    // Wide instance: top address, all three ports, no alias into 15.
    d_wb_en = 1'b1; d_wb_addr = 5'd31; d_wb_data = 32'hDEADBEEF;
    d_rx = 5'd31; d_ry = 5'd31; d_rz = 5'd31;
    next_cycle();
    d_wb_en = 1'b0; d_wb_data = '0;
    @(negedge clk);
    chk("wide rx", d_rxv, 32'hDEADBEEF);
    chk("wide ry", d_ryv, 32'hDEADBEEF);
    chk("wide rz", d_rzv, 32'hDEADBEEF);
    d_rx = 5'd15;
    #1;
    chk("wide a15", d_rxv, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
